uart_program_loader: RTL and testbench
======================================

# uart_program_loader

Upstream program source for the simple CPU: receives a program image over a UART (8N1), stores it in an internal instruction RAM, and serves it to the CPU's boot-time copy loop through the `rom_addr`/`rom_data` pair. The loader holds the CPU in reset until a frame with a valid checksum has been written. It then releases the CPU. A new frame arriving later forces a reload.

## Interface
- `WIDTH_I`, default 32: instruction word width; must be a multiple of 8.
- `DEPTH_I`, default 8: address width; the RAM holds 2^DEPTH_I words.
- `BAUD_DIV`, default 434: clock cycles per UART bit; minimum 4.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `uart_rxd`  in  1  serial input, idle high, asynchronous to `clk`.
- `rom_addr`  in  DEPTH_I  CPU read address.
- `rom_data`  out  WIDTH_I  registered read data.
- `cpu_reset`  out  1  active-high reset to the CPU.
- `load_busy`  out  1  high while a frame is in progress.
- `load_error`  out  1  sticky; set by a failed frame, cleared by the next sync byte.

## Operation
- Frame format: sync byte `0xA5`, length byte L, then (L+1) words, then one checksum byte.
  - Word count is 1..256, capped at 2^DEPTH_I. Excess words are received and checked but not written.
  - Each word is WIDTH_I/8 bytes, little-endian.
  - The checksum is the XOR of all data bytes (sync and length bytes excluded).
- States and transitions:
  - IDLE: non-`0xA5` bytes are ignored. `0xA5` leads to LEN.
  - LEN: latches L and clears the word index, byte index and running XOR, then goes to DATA.
  - DATA: assembles bytes into a word. On the final byte of a word, writes the RAM at the word index and increments the index. After the last word, goes to SUM.
  - SUM: if the byte equals the running XOR, goes to RUN. Otherwise sets `load_error` and goes to IDLE.
  - RUN: `cpu_reset` is low. `0xA5` asserts `cpu_reset`, clears `load_error`, and goes to LEN. All other bytes are ignored.
- `cpu_reset` is high in every state except RUN. `load_busy` is high in LEN, DATA and SUM.
- RAM contents are not cleared by reset or reload. Words beyond the loaded length keep their previous values.
- Framing error (stop bit sampled low): the byte is discarded. In LEN, DATA or SUM this sets `load_error` and returns to IDLE. In IDLE or RUN it is ignored.
- Receiver:
  - 2-flop synchroniser on `uart_rxd`.
  - Start edge, then re-check at BAUD_DIV/2. A low sample proceeds; a high sample is a glitch and the receiver returns to idle.
  - Data bits are sampled every BAUD_DIV cycles, LSB first, followed by the stop-bit sample.
  - `byte_valid` pulses for 1 cycle at the stop-bit sample.

## Timing
- Reset values: `cpu_reset`=1, `load_busy`=0, `load_error`=0, `rom_data`=0, state IDLE, receiver idle.
- `rom_data` has 1-cycle latency: `rom_addr` sampled at edge k appears on `rom_data` after edge k. Reads are independent of loader state.
- Registered outputs are updated on the clock edge following the `byte_valid` cycle. This applies to:
  - the RAM write;
  - the fall of `cpu_reset` on a good checksum;
  - the rise of `cpu_reset` on a sync byte in RUN.
- Simultaneous RAM write and read of the same address return the old data.
- Reset asserted mid-frame: the frame is abandoned and the block restarts in IDLE with `cpu_reset`=1. RAM contents are undefined only for a write interrupted in that cycle.

## Structure
- Shared package holds the `SYNC_BYTE` constant (`0xA5`) and the state enumeration (IDLE, LEN, DATA, SUM, RUN).
- Sub-module `uart_rx`: synchroniser, bit timing, `byte_valid`/`byte_data`/`frame_err` outputs.
- The RAM is a simple dual-port inferred array inside the top level.

## Test plan
All tests use BAUD_DIV=4.
- Reset only -> `cpu_reset`=1, `load_busy`=0, `load_error`=0, `rom_data`=0.
- Send `A5 01 78 56 34 12 EF BE AD DE 2A` -> `cpu_reset` falls after the last byte.
  - `rom_addr`=0 gives `rom_data`=`0x12345678` next cycle.
  - `rom_addr`=1 gives `0xDEADBEEF`.
- Same frame with checksum `2B` -> `load_error`=1, `cpu_reset` stays 1. A following good frame clears the error and releases the CPU.
- Stop bit forced low on the 3rd data byte -> `load_error`=1, state IDLE, `cpu_reset`=1.
- In RUN, send `A5` -> `cpu_reset`=1 and `load_busy`=1 one cycle after `byte_valid`. Reload `00 44 33 22 11 44` -> word 0 = `0x11223344`, CPU released.
- Junk bytes `00 FF 5A` plus a 1-cycle low glitch on `uart_rxd` before a valid frame -> no state change until `A5`; the frame then loads correctly.

Source files
------------

// File: rtl/uart_program_loader_pkg.sv
// Shared constants for the UART program loader: sync byte, loader state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_program_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_LEN  = 3'd1;
    localparam state_t ST_DATA = 3'd2;
    localparam state_t ST_SUM  = 3'd3;
    localparam state_t ST_RUN  = 3'd4;

    // A frame is "in progress" from the sync byte until its checksum byte.
    function automatic logic is_busy(state_t s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_SUM);
    endfunction

endpackage

// File: rtl/uart_program_loader_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, glitch-rejecting start check.
// Latency: byte_valid_o pulses one cycle after the stop-bit sample edge.
// Backpressure: none; the consumer must accept every byte_valid_o pulse.
module uart_rx #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] FULL_CNT = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(BAUD_DIV / 2 - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic [1:0]    sync_q;
    logic [1:0]    st_q,    st_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [2:0]    bit_q,   bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          vld_q,   vld_d;
    logic          err_q,   err_d;
    logic          rxd_s;

    assign rxd_s        = sync_q[1];
    assign byte_valid_o = vld_q;
    assign byte_data_o  = shift_q;
    assign frame_err_o  = err_q;

    // Bring the asynchronous line into the clock domain; idle level is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], rxd_i};
    end

    // Bit timing: half a bit to the start-bit centre, then one full bit per sample.
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        vld_d   = 1'b0;
        err_d   = err_q;
        case (st_q)
            RX_IDLE: begin
                if (!rxd_s) begin
                    st_d  = RX_START;
                    cnt_d = HALF_CNT;
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    // A high line at the start-bit centre was only a glitch.
                    if (!rxd_s) begin
                        st_d  = RX_DATA;
                        cnt_d = FULL_CNT;
                        bit_d = 3'd0;
                    end else begin
                        st_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rxd_s, shift_q[7:1]};
                    cnt_d   = FULL_CNT;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) st_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    vld_d = 1'b1;
                    err_d = !rxd_s;
                    st_d  = RX_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    // Receiver state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q    <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: rtl/uart_program_loader.sv
// Loads a checksummed program frame from UART into instruction RAM and gates the CPU reset.
// Latency: state/RAM update one edge after byte_valid; rom_data one cycle after rom_addr.
// Backpressure: none; UART bytes are consumed at line rate, CPU reads are always served.
module uart_program_loader
    import uart_program_loader_pkg::*;
#(
    parameter int WIDTH_I  = 32,
    parameter int DEPTH_I  = 8,
    parameter int BAUD_DIV = 434
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               uart_rxd,
    input  logic [DEPTH_I-1:0] rom_addr,
    output logic [WIDTH_I-1:0] rom_data,
    output logic               cpu_reset,
    output logic               load_busy,
    output logic               load_error
);

    localparam int NB     = WIDTH_I / 8;
    localparam int BIW    = (NB > 1) ? $clog2(NB) : 1;
    localparam int NWORDS = 1 << DEPTH_I;

    logic               rx_vld;
    logic [7:0]         rx_data;
    logic               rx_err;

    state_t             state_q, state_d;
    logic [7:0]         len_q,   len_d;
    logic [8:0]         widx_q,  widx_d;
    logic [BIW-1:0]     bidx_q,  bidx_d;
    logic [7:0]         xor_q,   xor_d;
    logic [WIDTH_I-1:0] word_q,  word_d;
    logic               err_q,   err_d;
    logic [WIDTH_I-1:0] asm_word;
    logic               wr_en;
    logic [DEPTH_I-1:0] wr_addr;
    logic [WIDTH_I-1:0] mem_q [NWORDS];
    logic [WIDTH_I-1:0] rom_data_q;

    uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk          (clk),
        .reset        (reset),
        .rxd_i        (uart_rxd),
        .byte_valid_o (rx_vld),
        .byte_data_o  (rx_data),
        .frame_err_o  (rx_err)
    );

    assign cpu_reset  = (state_q != ST_RUN);
    assign load_busy  = is_busy(state_q);
    assign load_error = err_q;
    assign rom_data   = rom_data_q;
    assign wr_addr    = DEPTH_I'(widx_q);

    // Frame parser: one decision per received byte, little-endian word assembly.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        widx_d   = widx_q;
        bidx_d   = bidx_q;
        xor_d    = xor_q;
        word_d   = word_q;
        err_d    = err_q;
        wr_en    = 1'b0;
        asm_word = word_q;
        asm_word[{bidx_q, 3'b000} +: 8] = rx_data;
        if (rx_vld) begin
            if (rx_err) begin
                // A corrupted byte only matters if it lands inside a frame.
                if (is_busy(state_q)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end else begin
                case (state_q)
                    ST_IDLE, ST_RUN: begin
                        if (rx_data == SYNC_BYTE) begin
                            state_d = ST_LEN;
                            err_d   = 1'b0;
                        end
                    end
                    ST_LEN: begin
                        len_d   = rx_data;
                        widx_d  = '0;
                        bidx_d  = '0;
                        xor_d   = '0;
                        state_d = ST_DATA;
                    end
                    ST_DATA: begin
                        xor_d  = xor_q ^ rx_data;
                        word_d = asm_word;
                        if (bidx_q == BIW'(NB - 1)) begin
                            bidx_d = '0;
                            widx_d = widx_q + 9'd1;
                            // Words past the RAM end still count toward the checksum.
                            wr_en  = (int'(widx_q) < NWORDS);
                            if (widx_q == {1'b0, len_q}) state_d = ST_SUM;
                        end else begin
                            bidx_d = bidx_q + BIW'(1);
                        end
                    end
                    ST_SUM: begin
                        if (rx_data == xor_q) begin
                            state_d = ST_RUN;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    // Loader registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            widx_q  <= '0;
            bidx_q  <= '0;
            xor_q   <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            widx_q  <= widx_d;
            bidx_q  <= bidx_d;
            xor_q   <= xor_d;
            word_q  <= word_d;
            err_q   <= err_d;
        end
    end

    // Instruction RAM write port; contents survive reset and reloads.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= asm_word;
    end

    // Registered CPU read port; a same-cycle write to the same word returns old data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rom_data_q <= '0;
        else        rom_data_q <= mem_q[rom_addr];
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench: byte-level reference model of the loader, per-cycle compare, random frames.
// Latency: model updates after each byte's gap; compare masked while the DUT may be settling.
// Backpressure: n/a.
module tb_uart_program_loader;

    localparam int W  = 32;
    localparam int D  = 3;
    localparam int B  = 4;
    localparam int NW = 1 << D;
    localparam int MI = 0, ML = 1, MD = 2, MS = 3, MR = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          uart_rxd;
    logic [D-1:0]  rom_addr;
    logic [W-1:0]  rom_data;
    logic          cpu_reset, load_busy, load_error;

    uart_program_loader #(.WIDTH_I(W), .DEPTH_I(D), .BAUD_DIV(B)) dut (
        .clk(clk), .reset(reset), .uart_rxd(uart_rxd), .rom_addr(rom_addr),
        .rom_data(rom_data), .cpu_reset(cpu_reset), .load_busy(load_busy),
        .load_error(load_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_on = 0, settling = 0, dir_rom = 0, done = 0, rd_pend = 0;
    logic [D-1:0] dir_addr = '0, rd_addr = '0;

    // Reference model state
    int         m_mode = MI, m_widx = 0, m_nwords = 0;
    bit         m_err = 0;
    logic [7:0] m_xs = 0;
    logic [7:0] m_bq[$];
    logic [W-1:0] m_mem [NW];
    bit         m_vld [NW];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_byte(input logic [7:0] b, input bit ferr);
        if (ferr) begin
            if (m_mode == ML || m_mode == MD || m_mode == MS) begin
                m_err  = 1;
                m_mode = MI;
            end
            return;
        end
        case (m_mode)
            MI, MR: if (b == 8'hA5) begin m_mode = ML; m_err = 0; end
            ML: begin
                m_nwords = int'(b) + 1; m_widx = 0; m_xs = 0;
                m_bq.delete(); m_mode = MD;
            end
            MD: begin
                m_xs ^= b;
                m_bq.push_back(b);
                if (m_bq.size() == W / 8) begin
                    if (m_widx < NW) begin
                        m_mem[m_widx] = {m_bq[3], m_bq[2], m_bq[1], m_bq[0]};
                        m_vld[m_widx] = 1;
                    end
                    m_widx++;
                    m_bq.delete();
                    if (m_widx == m_nwords) m_mode = MS;
                end
            end
            MS: begin
                if (b == m_xs) m_mode = MR;
                else begin m_err = 1; m_mode = MI; end
            end
            default: m_mode = MI;
        endcase
    endfunction

    task automatic drive(input logic v, input int n);
        @(posedge clk); #1;
        uart_rxd = v;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ferr);
        drive(1'b0, B);
        for (int i = 0; i < 8; i++) drive(b[i], B);
        settling = 1;
        drive(!ferr, B);
        drive(1'b1, 8);
        #1;
        m_byte(b, ferr);
        settling = 0;
    endtask

    task automatic send_seq(input logic [7:0] q[$], input int ferr_idx);
        foreach (q[i]) send_byte(q[i], i == ferr_idx);
    endtask

    task automatic glitch();
        @(posedge clk); #1 uart_rxd = 1'b0;
        @(posedge clk); #1 uart_rxd = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    task automatic rom_lit(input string name, input logic [D-1:0] a, input logic [W-1:0] exp);
        dir_addr = a;
        dir_rom  = 1;
        @(negedge clk);
        @(negedge clk); #1;
        chk(name, rom_data, exp);
        dir_rom = 0;
    endtask

    // Per-cycle comparison against the model, plus random CPU reads.
    initial begin
        while (!done) begin
            @(negedge clk);
            if (chk_on && !settling) begin
                chk("cpu_reset", cpu_reset, (m_mode != MR));
                chk("load_busy", load_busy, (m_mode == ML || m_mode == MD || m_mode == MS));
                chk("load_error", load_error, m_err);
                if (rd_pend && m_vld[rd_addr]) chk("rom_rand", rom_data, m_mem[rd_addr]);
            end
            rd_addr  = dir_rom ? dir_addr : D'($urandom);
            rom_addr = rd_addr;
            rd_pend  = chk_on && !settling && !dir_rom;
        end
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] good[$], badf[$], q[$];
        int rise, c;
        bit seen, busy_at;
        good = '{8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
        badf = good;
        badf[10] = 8'h2B;
        reset = 1'b0;
        uart_rxd = 1'b1;
        rom_addr = '0;
        repeat (4) @(posedge clk);
        #2;
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_load_busy", load_busy, 0);
        chk("rst_load_error", load_error, 0);
        chk("rst_rom_data", rom_data, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        chk_on = 1;

        // Good frame
        send_seq(good, -1);
        chk("good_cpu_released", cpu_reset, 0);
        rom_lit("rom0_first", 0, 32'h12345678);
        rom_lit("rom1_first", 1, 32'hDEADBEEF);

        // Bad checksum, then good frame clears error
        send_seq(badf, -1);
        chk("badsum_error", load_error, 1);
        chk("badsum_cpu_reset", cpu_reset, 1);
        send_seq(good, -1);
        chk("recover_error", load_error, 0);
        chk("recover_cpu", cpu_reset, 0);

        // Framing error on 3rd data byte (frame index 4)
        send_seq(good, 4);
        chk("ferr_error", load_error, 1);
        chk("ferr_cpu_reset", cpu_reset, 1);
        chk("ferr_busy", load_busy, 0);

        // Reload from RUN: cpu_reset and load_busy rise together around the stop bit
        send_seq(good, -1);
        chk("run_before_sync", cpu_reset, 0);
        seen = 0; rise = 0; busy_at = 0;
        fork
            send_byte(8'hA5, 0);
            begin
                for (c = 1; c <= 50; c++) begin
                    @(posedge clk); #1;
                    if (!seen && cpu_reset) begin
                        seen = 1; rise = c; busy_at = load_busy;
                    end
                end
            end
        join
        chk("sync_rise_in_stop_window", (seen && rise >= 38 && rise <= 47), 1);
        chk("sync_busy_with_reset", busy_at, 1);
        q = '{8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h44};
        send_seq(q, -1);
        chk("reload_cpu", cpu_reset, 0);
        rom_lit("reload_rom0", 0, 32'h11223344);
        rom_lit("reload_rom1_kept", 1, 32'hDEADBEEF);

        // Junk and a glitch while idle, then a valid frame
        send_seq(badf, -1);
        q = '{8'h00, 8'hFF, 8'h5A};
        send_seq(q, -1);
        glitch();
        chk("junk_error_held", load_error, 1);
        chk("junk_cpu_held", cpu_reset, 1);
        send_seq(good, -1);
        chk("junk_then_good", cpu_reset, 0);
        rom_lit("junk_rom0", 0, 32'h12345678);

        // Randomized frames against the model
        for (int f = 0; f < 15; f++) begin
            logic [7:0] xs;
            int L, fe, k;
            q.delete();
            k = $urandom_range(0, 2);
            for (int j = 0; j < k; j++) begin
                logic [7:0] jb;
                jb = 8'($urandom);
                if (jb == 8'hA5) jb = 8'h00;
                q.push_back(jb);
            end
            send_seq(q, -1);
            if ($urandom_range(0, 3) == 0) glitch();
            q.delete();
            L = $urandom_range(0, 10);
            q.push_back(8'hA5);
            q.push_back(8'(L));
            xs = 0;
            for (int j = 0; j < (L + 1) * (W / 8); j++) begin
                logic [7:0] db;
                db = 8'($urandom);
                xs ^= db;
                q.push_back(db);
            end
            if ($urandom_range(0, 4) == 0) xs ^= 8'(1 << $urandom_range(0, 7));
            q.push_back(xs);
            fe = ($urandom_range(0, 6) == 0) ? $urandom_range(1, q.size() - 1) : -1;
            send_seq(q, fe);
            repeat (4) @(posedge clk);
        end

        chk_on = 0;
        done = 1;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
